// File: rtl/module_types.sv
// Shared rename-stage widths and types: physical register addressing and free-list pointers.
package module_types;

    localparam int unsigned PHYS_REGS         = 64;
    localparam int unsigned ARCH_REGS         = 32;
    localparam int unsigned PHYS_REG_ADDR     = $clog2(PHYS_REGS);
    localparam int unsigned HALF_PHYS_REGSIZE = PHYS_REGS / 2;

    localparam int unsigned FREE_LIST_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FL_PTR_W        = $clog2(FREE_LIST_DEPTH) + 1;
    localparam int unsigned FL_IDX_W        = FL_PTR_W - 1;

    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register indices: pops one per cycle to rename,
// takes back old mappings at commit, and rewinds the head to the committed point on flush.
module free_list
    import module_types::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     rename_req,
    output logic [PHYS_REG_ADDR-1:0] free_phys_addr,
    output logic                     free_valid,
    input  logic                     commit_en,
    input  logic [PHYS_REG_ADDR-1:0] commit_old_phys,
    output logic [FL_PTR_W-1:0]      free_count
);

    logic [PHYS_REG_ADDR-1:0] entries [FREE_LIST_DEPTH];

    fl_ptr_t head_q, tail_q, ret_head_q;
    fl_ptr_t head_d, tail_d, ret_head_d;

    logic empty, full, pop, push;

    // Status from registered state only; the extra MSB disambiguates full from empty.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[FL_IDX_W-1:0] == tail_q[FL_IDX_W-1:0]) &&
                   (head_q[FL_PTR_W-1] != tail_q[FL_PTR_W-1]);

    assign free_valid     = !empty;
    assign free_phys_addr = entries[head_q[FL_IDX_W-1:0]];
    assign free_count     = tail_q - head_q;

    assign pop  = rename_req && !empty && !flush;
    assign push = commit_en && !full;

    // Pointer next-state; flush rewinds head to the committed head including this cycle's commit.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        ret_head_d = ret_head_q;
        if (push) begin
            tail_d     = tail_q + fl_ptr_t'(1);
            ret_head_d = ret_head_q + fl_ptr_t'(1);
        end
        if (flush) begin
            head_d = ret_head_d;
        end else if (pop) begin
            head_d = head_q + fl_ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FREE_LIST_DEPTH); i++) begin
                entries[i] <= PHYS_REG_ADDR'(ARCH_REGS + unsigned'(i));
            end
            head_q     <= '0;
            ret_head_q <= '0;
            tail_q     <= {1'b1, {FL_IDX_W{1'b0}}};
        end else begin
            if (push) begin
                entries[tail_q[FL_IDX_W-1:0]] <= commit_old_phys;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            ret_head_q <= ret_head_d;
        end
    end

    // Protocol checks; an empty-list rename request is tolerated and merely reported.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (commit_en) begin
                assert (commit_old_phys != '0)
                    else $error("free_list: phys reg 0 returned at commit");
                assert (!full)
                    else $error("free_list: commit push while list is full");
            end
            if (rename_req && !flush) begin
                assert (!empty)
                    else $warning("free_list: rename request while list is empty");
            end
        end
    end

endmodule
